// File: rtl/sobel_window_if.sv
// sobel_window_if: strobe/status bundle between the pixel source and the Sobel frame sequencer
interface sobel_window_if #(
    parameter int CW = 10,
    parameter int RW = 9
);
    logic          frame_start_i;
    logic          pix_valid_i;
    logic          wr_ena_o;
    logic          buf_clr_o;
    logic          win_valid_o;
    logic [CW-1:0] win_col_o;
    logic [RW-1:0] win_row_o;
    logic          line_end_o;
    logic          frame_done_o;
    logic          busy_o;
    logic          err_o;

    modport master (
        output frame_start_i, pix_valid_i,
        input  wr_ena_o, buf_clr_o, win_valid_o, win_col_o, win_row_o,
               line_end_o, frame_done_o, busy_o, err_o
    );

    modport slave (
        input  frame_start_i, pix_valid_i,
        output wr_ena_o, buf_clr_o, win_valid_o, win_col_o, win_row_o,
               line_end_o, frame_done_o, busy_o, err_o
    );
endinterface

// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl: frame sequencer gating line-buffer writes and flagging interior 3x3 windows
module sobel_window_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 10,
    parameter int RW    = 9
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    sobel_window_if.slave bus
);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] col_q, col_d, win_col_q;
    logic [RW-1:0] row_q, row_d, win_row_q;
    logic          buf_clr_q, win_valid_q, line_end_q, frame_done_q, err_q;
    logic          accept, col_last, last_pix, win_hit, proto_err;

    assign accept    = bus.pix_valid_i && state_q == RUN;
    assign col_last  = col_q == C_LAST;
    assign last_pix  = col_last && row_q == R_LAST;
    assign win_hit   = accept && row_q >= RW'(2) && col_q >= CW'(2);
    assign proto_err = (bus.pix_valid_i && state_q != RUN) || (bus.frame_start_i && state_q != IDLE);

    assign bus.wr_ena_o     = accept;
    assign bus.buf_clr_o    = buf_clr_q;
    assign bus.win_valid_o  = win_valid_q;
    assign bus.win_col_o    = win_col_q;
    assign bus.win_row_o    = win_row_q;
    assign bus.line_end_o   = line_end_q;
    assign bus.frame_done_o = frame_done_q;
    assign bus.busy_o       = state_q != IDLE;
    assign bus.err_o        = err_q;

    // raster position of the next pixel: zeroed in CLEAR, advanced per accepted pixel
    always_comb begin
        col_d = state_q == CLEAR ? '0 : accept ? (col_last ? '0 : col_q + CW'(1)) : col_q;
        row_d = state_q == CLEAR ? '0 : (accept && col_last) ? row_q + RW'(1) : row_q;
    end

    // frame FSM with registered strobes, window tag and sticky error
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_i) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            buf_clr_q    <= 1'b0;
            win_valid_q  <= 1'b0;
            win_col_q    <= '0;
            win_row_q    <= '0;
            line_end_q   <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            buf_clr_q    <= 1'b0;
            frame_done_q <= 1'b0;
            win_valid_q  <= win_hit;
            line_end_q   <= accept && col_last;
            err_q        <= proto_err || (err_q && state_q != CLEAR);
            if (win_hit) begin
                win_col_q <= col_q - CW'(1);
                win_row_q <= row_q - RW'(1);
            end
            case (state_q)
                IDLE: if (bus.frame_start_i) begin
                    state_q   <= CLEAR;
                    buf_clr_q <= 1'b1;
                end
                CLEAR: state_q <= RUN;
                RUN: if (accept && last_pix) begin
                    state_q      <= DONE;
                    frame_done_q <= 1'b1;
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb_sobel_window_ctrl: randomized directed frames checked against a pixel-index reference model
module tb_sobel_window_ctrl;
    localparam int W = 5;
    localparam int H = 4;

    localparam int M_IDLE  = 0;
    localparam int M_CLEAR = 1;
    localparam int M_RUN   = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    sobel_window_if #(.CW(3), .RW(3)) bus ();

    sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .CW(3), .RW(3)) dut (
        .sys_clk_i(clk),
        .sys_rst_i(rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int   m_mode, m_n, e_wc, e_wr;
    logic m_err, e_clr, e_win, e_le, e_done;

    int n_wr, n_le, n_done, n_clr;
    int win_q[$];
    int exp_win[6] = '{101, 102, 103, 201, 202, 203};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_wr = 0; n_le = 0; n_done = 0; n_clr = 0;
        win_q.delete();
    endtask

    task automatic check_regs();
        chk("buf_clr", bus.buf_clr_o, e_clr);
        chk("win_valid", bus.win_valid_o, e_win);
        chk("win_col", bus.win_col_o, e_wc);
        chk("win_row", bus.win_row_o, e_wr);
        chk("line_end", bus.line_end_o, e_le);
        chk("frame_done", bus.frame_done_o, e_done);
        chk("busy", bus.busy_o, m_mode != M_IDLE);
        chk("err", bus.err_o, m_err);
    endtask

    task automatic step(input logic fs, input logic pv);
        int   r, c;
        logic acc, bad;
        bus.frame_start_i = fs;
        bus.pix_valid_i   = pv;
        #1;
        acc = pv && m_mode == M_RUN;
        chk("wr_ena", bus.wr_ena_o, acc);
        if (bus.wr_ena_o === 1'b1) n_wr++;
        r      = m_n / W;
        c      = m_n % W;
        e_clr  = m_mode == M_IDLE && fs;
        e_win  = acc && r >= 2 && c >= 2;
        e_le   = acc && c == W - 1;
        e_done = acc && m_n == W * H - 1;
        if (e_win) begin
            e_wr = r - 1;
            e_wc = c - 1;
        end
        bad   = (pv && m_mode != M_RUN) || (fs && m_mode != M_IDLE);
        m_err = bad || (m_err && m_mode != M_CLEAR);
        if (acc) m_n++;
        case (m_mode)
            M_IDLE:  if (fs) begin m_mode = M_CLEAR; m_n = 0; end
            M_CLEAR: m_mode = M_RUN;
            M_RUN:   if (e_done) m_mode = M_DONE;
            default: m_mode = M_IDLE;
        endcase
        @(posedge clk);
        #1;
        check_regs();
        if (bus.win_valid_o === 1'b1) win_q.push_back(int'(bus.win_row_o) * 100 + int'(bus.win_col_o));
        if (bus.line_end_o === 1'b1) n_le++;
        if (bus.frame_done_o === 1'b1) n_done++;
        if (bus.buf_clr_o === 1'b1) n_clr++;
    endtask

    task automatic do_reset();
        bus.frame_start_i = 1'b0;
        bus.pix_valid_i   = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        m_mode = M_IDLE; m_n = 0; m_err = 1'b0;
        e_clr = 1'b0; e_win = 1'b0; e_le = 1'b0; e_done = 1'b0;
        e_wc = 0; e_wr = 0;
        check_regs();
    endtask

    task automatic run_frame(input logic gaps, input logic inject, input logic start_pix);
        int   guard = 0;
        logic injected = 1'b0;
        logic fs, pv;
        clear_stats();
        step(1'b1, start_pix);
        while (m_mode != M_IDLE && guard < 500) begin
            pv = m_mode == M_RUN && (!gaps || $urandom_range(0, 1) == 1);
            fs = inject && !injected && m_mode == M_RUN && m_n == 7;
            if (fs) injected = 1'b1;
            step(fs, pv);
            guard++;
        end
        chk("frame_timeout", guard < 500, 1'b1);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_wr_count"}, n_wr, W * H);
        chk({tag, "_line_ends"}, n_le, H);
        chk({tag, "_frame_done"}, n_done, 1);
        chk({tag, "_buf_clr"}, n_clr, 1);
        chk({tag, "_win_count"}, win_q.size(), 6);
        for (int i = 0; i < 6; i++)
            chk({tag, "_win_coord"}, i < win_q.size() ? win_q[i] : -1, exp_win[i]);
    endtask

    initial begin
        bus.frame_start_i = 1'b0;
        bus.pix_valid_i   = 1'b0;
        do_reset();

        run_frame(1'b0, 1'b0, 1'b0);
        check_frame("dense");

        run_frame(1'b1, 1'b0, 1'b0);
        check_frame("gappy");

        clear_stats();
        for (int i = 0; i < 4; i++) step(1'b0, (i % 2) == 0);
        chk("idle_err_sticky", bus.err_o, 1'b1);
        chk("idle_no_writes", n_wr, 0);
        run_frame(1'b1, 1'b0, 1'b0);
        check_frame("after_err");
        chk("err_cleared", bus.err_o, 1'b0);

        run_frame(1'b1, 1'b1, 1'b0);
        check_frame("inject_start");
        chk("inject_err", bus.err_o, 1'b1);

        run_frame(1'b0, 1'b0, 1'b1);
        check_frame("start_with_pix");

        clear_stats();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1);
        do_reset();
        chk("reset_busy", bus.busy_o, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("reset_no_done", n_done, 0);
        run_frame(1'b1, 1'b0, 1'b0);
        check_frame("post_reset");

        run_frame(1'b0, 1'b0, 1'b0);
        check_frame("b2b_first");
        run_frame(1'b1, 1'b0, 1'b0);
        check_frame("b2b_second");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sobel_window_ctrl.md
Name:
sobel_window_ctrl

Overview:
- Frame sequencer for the Sobel 3x3 window path.
- Sits between the greyscale converter output strobe and the line-buffer/window-assembly chain.
- Gates pixel writes into the line buffers and clears them between frames.
- Tracks column/row of every accepted pixel and flags which accepted pixels complete a 3x3 window fully inside the image, tagged with the window-centre coordinate. Border windows are suppressed.
- Emits line-end and frame-done pulses and a sticky protocol-error flag.

Parameters:
IMG_W, 640, pixels per line (>=3)
IMG_H, 480, lines per frame (>=3)
CW, 10, column counter / coordinate width (2^CW >= IMG_W)
RW, 9, row counter / coordinate width (2^RW >= IMG_H)

Ports:
sys_clk_i  in  1  clock, all logic on rising edge
sys_rst_i  in  1  reset, synchronous, active-low
frame_start_i  in  1  one-cycle request to begin a frame
pix_valid_i  in  1  greyscale pixel strobe (one pixel per high cycle)
wr_ena_o  out  1  line-buffer write enable, combinational: pix_valid_i & (state==RUN)
buf_clr_o  out  1  line-buffer clear, registered, high exactly one cycle per frame
win_valid_o  out  1  registered; current window is complete and interior
win_col_o  out  CW  window-centre column, valid with win_valid_o
win_row_o  out  RW  window-centre row, valid with win_valid_o
line_end_o  out  1  registered pulse after the last pixel of each line is accepted
frame_done_o  out  1  registered pulse, frame complete
busy_o  out  1  high in CLEAR, RUN and DONE
err_o  out  1  sticky protocol error

Behaviour:
- Reset (sys_rst_i==0 at a clock edge): state=IDLE, col=0, row=0.
- All registered outputs reset to 0: buf_clr_o, win_valid_o, win_col_o, win_row_o, line_end_o, frame_done_o, err_o.
- Reset mid-frame abandons the frame. No frame_done_o is issued.
- FSM:
  - IDLE: frame_start_i=1 -> CLEAR.
  - CLEAR: buf_clr_o=1 this cycle. col=0, row=0, err_o cleared. Always -> RUN next cycle.
  - RUN: each cycle with pix_valid_i=1 accepts one pixel (wr_ena_o=1).
  - RUN, accepted pixel: if col==IMG_W-1 then col=0 and row=row+1; else col=col+1.
  - RUN -> DONE when the pixel at (row=IMG_H-1, col=IMG_W-1) is accepted.
  - DONE: frame_done_o=1 for this one cycle. -> IDLE.
- Window flag: for an accepted pixel at (r,c) with r>=2 and c>=2, next cycle gives win_valid_o=1, win_row_o=r-1, win_col_o=c-1. Latency 1 cycle.
- All other cycles: win_valid_o=0, and win_col_o/win_row_o hold their last value.
- Windows per frame = (IMG_W-2)*(IMG_H-2). The first window is flagged after pixel index 2*IMG_W+2.
- line_end_o: 1 the cycle after the accepted pixel has col==IMG_W-1, including the last pixel of the frame. For the final pixel, line_end_o, win_valid_o and the DONE state (frame_done_o) all occur in the same cycle.
- Gaps: pix_valid_i may drop in RUN for any number of cycles. Counters hold, and no outputs pulse.
- Protocol errors (set err_o=1, held until the next CLEAR or reset):
  - pix_valid_i=1 in IDLE, CLEAR or DONE. The pixel is dropped and wr_ena_o stays 0.
  - frame_start_i=1 in CLEAR, RUN or DONE. It is ignored and the frame continues.
- Simultaneous frame_start_i and pix_valid_i in IDLE: start is taken, pixel is dropped, err_o set. err_o is then cleared in CLEAR the next cycle, so the net visible effect is err_o high for one cycle.
- Counter wrap never occurs. The frame ends at the last pixel, and col/row are reset only in CLEAR, not in DONE.

Test Plan:
- IMG_W=5, IMG_H=4; pulse frame_start_i, then 20 back-to-back pix_valid_i -> buf_clr_o 1 cycle, 6 win_valid_o pulses with centres (1,1),(1,2),(1,3),(2,1),(2,2),(2,3). First pulse comes the cycle after the 13th pixel. 4 line_end_o pulses. frame_done_o 1 cycle after the 20th pixel. err_o=0 throughout.
- Same frame with pix_valid_i toggling 1-0-0-1 randomly -> identical window and coordinate sequence; wr_ena_o count = 20.
- pix_valid_i pulses while IDLE -> wr_ena_o=0, err_o=1 and stays 1. Next frame_start_i -> err_o=0 after CLEAR.
- frame_start_i asserted at pixel 7 of a frame -> ignored, err_o=1. Frame still completes with 6 windows and one frame_done_o.
- Assert sys_rst_i=0 for one cycle after pixel 14 -> all outputs 0, state IDLE, no frame_done_o. A new frame then produces the full 6-window sequence.
- Two frames back-to-back (frame_start_i the cycle after frame_done_o) -> two buf_clr_o pulses and 12 windows; second frame coordinates restart at (1,1).
